// File: rtl/fft_s2p_in.sv
// rtl/fft_s2p_in.sv - serial-to-parallel input stage of the 8-point FFT
// Assembles 8 handshaked samples into a frame, ping-ponging two banks toward the core.
module fft_s2p_in #(
  parameter int W      = 16,
  parameter bit BITREV = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_sof,
  output logic         in_ready,
  output logic [W-1:0] x0,
  output logic [W-1:0] x1,
  output logic [W-1:0] x2,
  output logic [W-1:0] x3,
  output logic [W-1:0] x4,
  output logic [W-1:0] x5,
  output logic [W-1:0] x6,
  output logic [W-1:0] x7,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sof_err
);

  logic [W-1:0] mem [2][8];
  logic [2:0]   wr_cnt;
  logic         wr_bank;
  logic         rd_bank;
  logic [1:0]   full;
  logic [1:0]   full_nxt;
  logic         accept;
  logic         consume;
  logic         complete;
  logic [2:0]   idx;
  logic [2:0]   slot;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign idx       = in_sof ? 3'd0 : wr_cnt;
  assign slot      = BITREV ? bitrev3(idx) : idx;
  assign complete  = accept && (idx == 3'd7);

  // A bank being filled is never the one being drained, so both updates can land together.
  always_comb begin
    full_nxt = full;
    if (consume)  full_nxt[rd_bank] = 1'b0;
    if (complete) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= 3'd0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      sof_err <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        wr_cnt <= idx + 3'd1;
        if (in_sof && (wr_cnt != 3'd0)) sof_err <= 1'b1;
      end
      if (complete) wr_bank <= !wr_bank;
      if (consume)  rd_bank <= !rd_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (accept) begin
      mem[wr_bank][slot] <= in_data;
    end
  end

  assign x0 = mem[rd_bank][0];
  assign x1 = mem[rd_bank][1];
  assign x2 = mem[rd_bank][2];
  assign x3 = mem[rd_bank][3];
  assign x4 = mem[rd_bank][4];
  assign x5 = mem[rd_bank][5];
  assign x6 = mem[rd_bank][6];
  assign x7 = mem[rd_bank][7];

endmodule

// File: tb/tb_fft_s2p_in.sv
// tb/tb_fft_s2p_in.sv - scoreboard bench for fft_s2p_in, natural and bit-reversed instances
module tb_fft_s2p_in;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        out_ready = 1'b0;

  logic        d0_in_ready, d0_out_valid, d0_sof_err;
  logic        d1_in_ready, d1_out_valid, d1_sof_err;
  logic [15:0] d0_x0, d0_x1, d0_x2, d0_x3, d0_x4, d0_x5, d0_x6, d0_x7;
  logic [15:0] d1_x0, d1_x1, d1_x2, d1_x3, d1_x4, d1_x5, d1_x6, d1_x7;
  logic [127:0] xa0, xa1;

  assign xa0 = {d0_x7, d0_x6, d0_x5, d0_x4, d0_x3, d0_x2, d0_x1, d0_x0};
  assign xa1 = {d1_x7, d1_x6, d1_x5, d1_x4, d1_x3, d1_x2, d1_x1, d1_x0};

  always #5 clk = ~clk;

  fft_s2p_in #(.W(16), .BITREV(1'b0)) u_nat (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(d0_in_ready),
    .x0(d0_x0), .x1(d0_x1), .x2(d0_x2), .x3(d0_x3), .x4(d0_x4), .x5(d0_x5), .x6(d0_x6), .x7(d0_x7),
    .out_valid(d0_out_valid), .out_ready(out_ready), .sof_err(d0_sof_err)
  );

  fft_s2p_in #(.W(16), .BITREV(1'b1)) u_rev (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(d1_in_ready),
    .x0(d1_x0), .x1(d1_x1), .x2(d1_x2), .x3(d1_x3), .x4(d1_x4), .x5(d1_x5), .x6(d1_x6), .x7(d1_x7),
    .out_valid(d1_out_valid), .out_ready(out_ready), .sof_err(d1_sof_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: frames are lists of accepted samples in arrival order.
  logic [127:0] fq[$];
  logic [127:0] pbuf = '0;
  int           pcnt = 0;
  int           held = 0;
  bit           exp_err = 1'b0;

  function automatic int rev3(input int n);
    return (n % 2) * 4 + ((n / 2) % 2) * 2 + (n / 4);
  endfunction

  function automatic logic [127:0] rev_frame(input logic [127:0] f);
    logic [127:0] r = '0;
    for (int n = 0; n < 8; n++) r[rev3(n)*16 +: 16] = f[n*16 +: 16];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        held = 0; pcnt = 0; exp_err = 1'b0; pbuf = '0; fq.delete();
      end else begin
        bit acc, cons;
        acc  = in_valid && (held < 2);
        cons = (held > 0) && out_ready;
        if (cons) held--;
        if (acc) begin
          if (in_sof) begin
            if (pcnt != 0) exp_err = 1'b1;
            pcnt = 0;
          end
          pbuf[pcnt*16 +: 16] = in_data;
          pcnt++;
          if (pcnt == 8) begin
            fq.push_back(pbuf);
            held++;
            pcnt = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        bit ev;
        ev = held > 0;
        chk("in_ready_nat", d0_in_ready, held < 2);
        chk("in_ready_rev", d1_in_ready, held < 2);
        chk("out_valid_nat", d0_out_valid, ev);
        chk("out_valid_rev", d1_out_valid, ev);
        chk("sof_err_nat", d0_sof_err, exp_err);
        chk("sof_err_rev", d1_sof_err, exp_err);
        if (ev) begin
          if (fq.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            chk("frame_nat", xa0, fq[0]);
            chk("frame_rev", xa1, rev_frame(fq[0]));
            if (out_ready) void'(fq.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input bit sof);
    int  n = 0;
    bit  acc = 1'b0;
    in_data = d; in_valid = 1'b1; in_sof = sof;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = d0_in_ready;
      tick();
      n++;
    end
    if (!acc) chk("drive_timeout", 1, 0);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  logic [15:0] exp_rev [8];
  bit acc_prev;

  initial begin
    exp_rev = '{16'h10, 16'h14, 16'h12, 16'h16, 16'h11, 16'h15, 16'h13, 16'h17};
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_x_nat", xa0, '0);
    chk("rst_x_rev", xa1, '0);
    chk("rst_out_valid", d0_out_valid, 0);
    chk("rst_in_ready", d1_in_ready, 1);
    chk("rst_sof_err", d0_sof_err, 0);
    tick();

    // Back-to-back frame, core always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive(16'h10 + 16'(i), i == 0);
    chk("lat_out_valid", d1_out_valid, 1);
    for (int i = 0; i < 8; i++) begin
      chk("nat_order", xa0[i*16 +: 16], 16'h10 + 16'(i));
      chk("rev_order", xa1[i*16 +: 16], exp_rev[i]);
    end
    tick();
    chk("one_cycle_valid", d0_out_valid, 0);

    // Backpressure: both banks fill, producer stalls.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) drive(16'h100 + 16'(i), i % 8 == 0);
    chk("bp_in_ready_low", d0_in_ready, 0);
    in_data = 16'h200; in_valid = 1'b1; in_sof = 1'b1;
    repeat (3) tick();
    chk("bp_hold_x0", d0_x0, 16'h100);
    chk("bp_hold_x7", d0_x7, 16'h107);
    chk("bp_still_stalled", d1_in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_frame2_x0", d0_x0, 16'h108);
    chk("bp_in_ready_back", d0_in_ready, 1);
    drive(16'h200, 1'b1);
    for (int i = 1; i < 8; i++) drive(16'h200 + 16'(i), 1'b0);
    out_ready = 1'b1;
    repeat (4) tick();

    // Truncated frame restarted by an early in_sof.
    chk("pre_sof_err", d0_sof_err, 0);
    for (int i = 0; i < 3; i++) drive(16'h301 + 16'(i), i == 0);
    drive(16'hAAAA, 1'b1);
    for (int i = 1; i < 8; i++) drive(16'h400 + 16'(i), 1'b0);
    chk("sof_err_set", d0_sof_err, 1);
    chk("sof_frame_valid", d0_out_valid, 1);
    chk("sof_frame_x0", d0_x0, 16'hAAAA);
    chk("sof_frame_x1", d0_x1, 16'h401);
    tick();
    chk("sof_once", d0_out_valid, 0);
    repeat (2) tick();

    // Asynchronous reset with one bank full and a partial frame pending.
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) drive(16'h600 + 16'(i), i == 0);
    chk("pre_rst_valid", d0_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", d0_out_valid, 0);
    chk("arst_in_ready", d1_in_ready, 1);
    chk("arst_x", xa0, '0);
    chk("arst_sof_err", d1_sof_err, 0);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) drive(16'h500 + 16'(i), i == 0);
    chk("post_rst_x0", d0_x0, 16'h500);
    chk("post_rst_x7", d0_x7, 16'h507);
    tick();

    // Random traffic against the model; the producer holds data while stalled.
    acc_prev = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || acc_prev) begin
        in_valid = $urandom_range(0, 9) < 7;
        in_sof   = in_valid && ($urandom_range(0, 9) == 0);
        in_data  = 16'($urandom);
      end
      out_ready = (c / 40) % 3 == 1 ? 1'b0 : ($urandom_range(0, 9) < 6);
      @(negedge clk);
      acc_prev = in_valid && d0_in_ready;
      tick();
    end
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    chk("drain_empty", fq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_s2p_in.md
Name: fft_s2p_in

Overview:
- Input stage of the 8-point FFT datapath. It accepts a serial stream of 16-bit samples with a valid/ready handshake.
- It assembles each run of 8 samples into one frame and presents the frame as eight parallel 16-bit words to the butterfly core.
- Two frame banks are ping-ponged, so the next frame can load while the core holds the current one.
- The optional bit-reversed write ordering delivers samples in the order the decimation-in-time core expects.

Parameters:
- W, 16, sample width in bits.
- BITREV, 1: 1 = sample n is stored at output index bitrev3(n); 0 = natural order.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  W  serial input sample.
- in_valid  input  1  in_data is valid this cycle.
- in_sof  input  1  start of frame; qualified by in_valid; marks the sample as frame index 0.
- in_ready  output  1  block can accept a sample this cycle.
- x0..x7  output  W each  parallel frame words, index 0..7.
- out_valid  output  1  x0..x7 hold a complete frame.
- out_ready  input  1  core consumes the frame this cycle.
- sof_err  output  1  sticky flag: a frame was truncated by an early in_sof.

Behaviour:
- Reset (asynchronous, active-low) clears the following:
  - both banks to 0, so x0..x7 read 0;
  - wr_cnt (3 bits) to 0, wr_bank to 0, rd_bank to 0;
  - full[1:0] to 00;
  - out_valid to 0, sof_err to 0.
- in_ready is 1 after reset. A reset in mid-frame discards all partial and held frames.
- in_ready = !full[wr_bank]. It is combinational from registered state only; it does not depend on in_valid.
- A sample is accepted when in_valid && in_ready. No state changes when in_valid=1 and in_ready=0; the producer must hold its data.
- Write index for an accepted sample:
  - idx = in_sof ? 0 : wr_cnt;
  - the storage slot is (BITREV ? bitrev3(idx) : idx) in bank wr_bank;
  - wr_cnt becomes idx+1, modulo 8.
- Early start of frame: if in_sof is accepted while wr_cnt != 0, the partial frame is abandoned and sof_err is set. Stale slots from the abandoned frame are overwritten as the new frame fills. sof_err clears only on reset.
- in_sof while wr_cnt == 0 is a normal frame start, with no error.
- Frame completion: when the accepted sample has idx == 7, full[wr_bank] is set to 1, wr_bank toggles and wr_cnt wraps to 0.
- out_valid = full[rd_bank]. x0..x7 are a mux of bank rd_bank.
- Output stability: while out_valid && !out_ready, x0..x7 and out_valid are held stable.
- Consumption: when out_valid && out_ready, full[rd_bank] is cleared and rd_bank toggles. The other bank may already be full, in which case out_valid stays 1 with the new frame on the next cycle.
- Latency: the last sample of a frame accepted at edge N gives out_valid=1 after edge N, so the frame is visible in cycle N+1.
- Throughput: 1 sample/cycle sustained, provided the core consumes each frame within 8 cycles of its out_valid.
- Simultaneous completion and consumption: if the bank being filled completes and the other bank is consumed in the same cycle, both updates apply. The two banks are distinct by construction.
- Both banks full: in_ready = 0 until the next consumption. in_ready returns to 1 in the cycle after the out_ready handshake.
- Control logic: wr/rd pointers plus the full bits. No other FSM.

Test Plan:
- Reset with no stimulus -> out_valid=0, in_ready=1, x0..x7=0, sof_err=0.
- BITREV=0: stream 1..8 back-to-back with in_sof on the first sample, out_ready=1 -> out_valid=1 for exactly one cycle, one cycle after the 8th sample; x0..x7 = 1,2,3,4,5,6,7,8.
- BITREV=1: stream 0x0010..0x0017 -> x0..x7 = 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17.
- out_ready=0 throughout, stream 24 samples -> first 16 accepted; in_ready=0 from the cycle after the 16th; x0..x7 hold frame 1 stable. Raise out_ready for one cycle -> frame 2 is shown next cycle; in_ready=1 again.
- 3 samples, then in_sof with 0xAAAA followed by 7 more samples -> sof_err=1; frame has x0=0xAAAA and contains none of the first 3 samples; out_valid asserted once.
- Assert rst_n=0 mid-frame with one bank full -> out_valid=0 and in_ready=1 immediately (asynchronous); the next full frame is output correctly.
